// File: rtl/acc_serial_tx.sv
// acc_serial_tx: byte-serial output port fed from the accumulator.
// Captures data_in on a load handshake and shifts it out as an asynchronous
// frame: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Optional feature macro: PARITY_EN (adds the PARITY state and parity bit).
// All outputs come straight from flops; there is no combinational path from
// load/data_in to tx.
module acc_serial_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       load,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  // Baud counter value on the last clock of a bit period.
  localparam logic [7:0] LAST_TICK = 8'(CLKS_PER_BIT - 1);

  state_t     state_q, state_d;
  logic [7:0] baudCnt_q, baudCnt_d;
  logic [2:0] bitIdx_q, bitIdx_d;
  logic [7:0] shiftReg_q, shiftReg_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
`ifdef PARITY_EN
  logic       parity_q, parity_d;
`endif
  logic       bitEnd;

  assign bitEnd = (baudCnt_q == LAST_TICK);

  // Next-state logic: baud timing, bit sequencing and the load handshake.
  always_comb begin
    state_d    = state_q;
    baudCnt_d  = baudCnt_q;
    bitIdx_d   = bitIdx_q;
    shiftReg_d = shiftReg_q;
    done_d     = 1'b0;
`ifdef PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          shiftReg_d = data_in;
          baudCnt_d  = '0;
          bitIdx_d   = '0;
          state_d    = START;
`ifdef PARITY_EN
          parity_d   = ^data_in;
`endif
        end
      end
      START: begin
        if (bitEnd) begin
          baudCnt_d = '0;
          bitIdx_d  = '0;
          state_d   = DATA;
        end else begin
          baudCnt_d = baudCnt_q + 8'd1;
        end
      end
      DATA: begin
        if (bitEnd) begin
          baudCnt_d  = '0;
          shiftReg_d = {1'b0, shiftReg_q[7:1]};
          bitIdx_d   = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          baudCnt_d = baudCnt_q + 8'd1;
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (bitEnd) begin
          baudCnt_d = '0;
          state_d   = STOP;
        end else begin
          baudCnt_d = baudCnt_q + 8'd1;
        end
      end
`endif
      STOP: begin
        if (bitEnd) begin
          baudCnt_d = '0;
          state_d   = IDLE;
          done_d    = 1'b1;
        end else begin
          baudCnt_d = baudCnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values for the upcoming cycle, derived from the next state so they can be registered.
  always_comb begin
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    tx_d    = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shiftReg_d[0];
`ifdef PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State and output registers; reset abandons any frame and idles the line high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baudCnt_q  <= '0;
      bitIdx_q   <= '0;
      shiftReg_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
`ifdef PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baudCnt_q  <= baudCnt_d;
      bitIdx_q   <= bitIdx_d;
      shiftReg_q <= shiftReg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
`ifdef PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule
